// File: rtl/router_tx.sv
// router_tx: WISHBONE-fed word FIFO feeding an LSB-first serial framer,
// 16 baud16x_ce ticks per bit, start bit 0 and STOP_BITS stop bits of 1.
module router_tx #(
  parameter int DATA_W = 128,
  parameter int FIFO_AW = 2,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic              ack_o,
  input  logic              we_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  input  logic              cs_i,
  input  logic              baud16x_ce,
  input  logic              clear,
  output logic              txd,
  output logic              busy,
  output logic              tx_empty,
  output logic              tx_full,
  output logic              overrun
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NBITS = DATA_W + STOP_BITS;
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic cs, wr, push_req, push, pop, full, empty;
  logic rdy1_q, wr_q, overrun_q, overrun_d, txd_q, txd_d;
  logic [0:0] state_q, state_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NBITS-1:0] sr_q, sr_d;
  logic [3:0] tick_q, tick_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  assign cs = cyc_i & stb_i & cs_i;
  assign ack_o = cs & rdy1_q;
  assign wr = cs & we_i;
  assign push_req = wr & ~wr_q;
  assign empty = count_q == '0;
  assign full = count_q == (FIFO_AW + 1)'(DEPTH);
  assign pop = baud16x_ce & (state_q == IDLE) & ~empty & ~clear;
  // a full FIFO still accepts a word when the head leaves on the same clock
  assign push = push_req & (~full | pop) & ~clear;
  assign busy = state_q == SHIFT;
  assign tx_empty = empty;
  assign tx_full = full;
  assign overrun = overrun_q;
  assign txd = txd_q;
  assign dat_o = ack_o ? {{(DATA_W - 4){1'b0}}, overrun_q, busy, full, empty} : '0;
  always_comb begin
    count_d = clear ? '0 : count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    wptr_d = clear ? '0 : wptr_q + FIFO_AW'(push);
    rptr_d = clear ? '0 : rptr_q + FIFO_AW'(pop);
    overrun_d = clear ? 1'b0 : overrun_q | (push_req & full & ~pop);
  end
  always_comb begin
    state_d = state_q;
    txd_d = txd_q;
    sr_d = sr_q;
    tick_d = tick_q;
    bcnt_d = bcnt_q;
    if (clear) begin
      state_d = IDLE;
      txd_d = 1'b1;
      tick_d = '0;
      bcnt_d = '0;
    end else if (baud16x_ce) begin
      if (state_q == IDLE) begin
        if (pop) begin
          // start bit goes out directly; sr holds payload then stop bits
          sr_d = {{STOP_BITS{1'b1}}, mem_q[rptr_q]};
          txd_d = 1'b0;
          tick_d = '0;
          bcnt_d = '0;
          state_d = SHIFT;
        end
      end else if (tick_q != 4'd15) begin
        tick_d = tick_q + 4'd1;
      end else if (bcnt_q == BW'(NBITS)) begin
        txd_d = 1'b1;
        tick_d = '0;
        state_d = IDLE;
      end else begin
        txd_d = sr_q[0];
        sr_d = sr_q >> 1;
        bcnt_d = bcnt_q + BW'(1);
        tick_d = '0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdy1_q <= 1'b0;
      wr_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      state_q <= IDLE;
      txd_q <= 1'b1;
      sr_q <= '0;
      tick_q <= '0;
      bcnt_q <= '0;
    end else begin
      rdy1_q <= cs;
      wr_q <= wr;
      overrun_q <= overrun_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      state_q <= state_d;
      txd_q <= txd_d;
      sr_q <= sr_d;
      tick_q <= tick_d;
      bcnt_q <= bcnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dat_i;
  end
endmodule

// File: tb/tb_router_tx.sv
// tb_router_tx: decodes txd frames tick by tick and checks them against a
// queue of words written over the bus, plus flag, clear and reset scenarios.
module tb_router_tx;
  localparam int DW = 128;
  localparam int NB = DW + 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cyc_i, stb_i, we_i, cs_i, baud16x_ce, clear;
  logic [DW-1:0] dat_i, dat_o;
  logic ack_o, txd, busy, tx_empty, tx_full, overrun;
  int vec, errs, ce_mode, cc, mt, starts, frames, gap, last_gap, start_cc, end_cc, push_cc;
  bit mon_on;
  logic last_txd;
  logic [NB-1:0] fb;
  logic [DW-1:0] exp_q[$];

  router_tx dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
    .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .cs_i(cs_i),
    .baud16x_ce(baud16x_ce), .clear(clear), .txd(txd), .busy(busy),
    .tx_empty(tx_empty), .tx_full(tx_full), .overrun(overrun)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_ce();
    int div = 0;
    forever begin
      @(negedge clk_i);
      div++;
      baud16x_ce = (ce_mode == 1) || (ce_mode == 2 && div % 4 == 0);
    end
  endtask

  task automatic monitor();
    logic ce_s, clr_s, rst_s;
    logic [DW-1:0] w;
    last_txd = 1'b1;
    forever begin
      @(posedge clk_i);
      cc++;
      ce_s = baud16x_ce;
      clr_s = clear;
      rst_s = rst_i;
      #1;
      if (!rst_s || clr_s || !rst_i) begin
        mon_on = 0;
        gap = 0;
      end else if (!ce_s) begin
        vec++;
        if (txd !== last_txd) begin
          errs++;
          $display("FAIL hold: txd=%b changed without ce, required %b", txd, last_txd);
        end
      end else if (!mon_on) begin
        if (txd === 1'b0) begin
          mon_on = 1;
          mt = 0;
          starts++;
          start_cc = cc;
          last_gap = gap;
        end else gap++;
      end else begin
        mt++;
        if (mt == NB * 16 - 1) begin
          vec++;
          if (busy !== 1'b1) begin
            errs++;
            $display("FAIL busy_last_tick: busy=%b required 1", busy);
          end
        end
        if (mt == NB * 16) begin
          mon_on = 0;
          gap = 1;
          end_cc = cc;
          frames++;
          vec++;
          if (txd !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL frame_end: txd=%b busy=%b required txd=1 busy=0", txd, busy);
          end
          vec++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_frame: got %h, none required", fb);
          end else begin
            w = exp_q.pop_front();
            if (fb !== {1'b1, w, 1'b0}) begin
              errs++;
              $display("FAIL frame: got %h required %h", fb, {1'b1, w, 1'b0});
            end
          end
        end else if (mt % 16 == 8) fb[mt / 16] = txd;
      end
      last_txd = txd;
    end
  endtask

  task automatic wb_write(input logic [DW-1:0] d, input bit accept);
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 1; dat_i = d;
    #1;
    vec++;
    if (ack_o !== 1'b0) begin
      errs++;
      $display("FAIL ack_first_cycle: ack=%b required 0", ack_o);
    end
    @(negedge clk_i);
    push_cc = cc;
    if (accept) exp_q.push_back(d);
    vec++;
    if (ack_o !== 1'b1) begin
      errs++;
      $display("FAIL ack_write: ack=%b required 1", ack_o);
    end
    @(negedge clk_i);
    cyc_i = 0; stb_i = 0; cs_i = 0; we_i = 0;
  endtask

  task automatic wb_read(output logic [DW-1:0] d);
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 0;
    #1;
    vec++;
    if (dat_o !== '0) begin
      errs++;
      $display("FAIL dat_o_no_ack: got %h required 0", dat_o);
    end
    @(negedge clk_i);
    d = dat_o;
    vec++;
    if (ack_o !== 1'b1) begin
      errs++;
      $display("FAIL ack_read: ack=%b required 1", ack_o);
    end
    @(negedge clk_i);
    cyc_i = 0; stb_i = 0; cs_i = 0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    for (int n = 0; n < budget && frames < target; n++) @(negedge clk_i);
    vec++;
    if (frames < target) begin
      errs++;
      $display("FAIL %s_timeout: frames=%0d required %0d", name, frames, target);
    end
  endtask

  task automatic test_reset();
    #2 rst_i = 0;
    #1;
    vec++;
    if ({txd, busy, tx_empty, tx_full, overrun, ack_o} !== 6'b101000 || dat_o !== '0) begin
      errs++;
      $display("FAIL reset: txd/busy/empty/full/ovr/ack=%b required 101000", {txd, busy, tx_empty, tx_full, overrun, ack_o});
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    vec++;
    if ({txd, busy, tx_empty, tx_full, overrun} !== 5'b10100) begin
      errs++;
      $display("FAIL after_reset: txd/busy/empty/full/ovr=%b required 10100", {txd, busy, tx_empty, tx_full, overrun});
    end
  endtask

  task automatic test_single();
    int s0 = starts;
    int f0 = frames;
    ce_mode = 1;
    repeat (2) @(negedge clk_i);
    wb_write(128'h1, 1);
    vec++;
    if (starts != s0 + 1 || start_cc != push_cc + 1) begin
      errs++;
      $display("FAIL start_latency: starts=%0d start_cc=%0d required %0d and %0d", starts - s0, start_cc, 1, push_cc + 1);
    end
    vec++;
    if (busy !== 1'b1 || tx_empty !== 1'b1) begin
      errs++;
      $display("FAIL single_flags: busy=%b empty=%b required 1 1", busy, tx_empty);
    end
    wait_frames(f0 + 1, 2200, "single");
    vec++;
    if (end_cc - start_cc != NB * 16) begin
      errs++;
      $display("FAIL single_len: got %0d clocks required %0d", end_cc - start_cc, NB * 16);
    end
  endtask

  task automatic test_ce_div();
    int f0 = frames;
    ce_mode = 2;
    wb_write({16{8'hA5}}, 1);
    wait_frames(f0 + 1, 8500, "ce_div");
    vec++;
    if (end_cc - start_cc != NB * 16 * 4) begin
      errs++;
      $display("FAIL ce_div_len: got %0d clocks required %0d", end_cc - start_cc, NB * 64);
    end
    ce_mode = 0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_overrun();
    logic [DW-1:0] d;
    ce_mode = 0;
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (tx_full !== 1'b0) begin
        errs++;
        $display("FAIL full_early: after %0d writes tx_full=%b required 0", i, tx_full);
      end
      wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    end
    vec++;
    if (tx_full !== 1'b1 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL full: tx_full=%b overrun=%b required 1 0", tx_full, overrun);
    end
    wb_write({DW{1'b1}}, 0);
    vec++;
    if (overrun !== 1'b1) begin
      errs++;
      $display("FAIL overrun: got %b required 1", overrun);
    end
    wb_read(d);
    vec++;
    if (d !== 128'ha) begin
      errs++;
      $display("FAIL status: got %h required %h", d, 128'ha);
    end
    @(negedge clk_i);
    clear = 1;
    @(negedge clk_i);
    clear = 0;
    exp_q.delete();
    vec++;
    if ({tx_empty, tx_full, overrun, txd} !== 4'b1001) begin
      errs++;
      $display("FAIL flush: empty/full/ovr/txd=%b required 1001", {tx_empty, tx_full, overrun, txd});
    end
  endtask

  task automatic test_back_to_back();
    int s0 = starts;
    int f0 = frames;
    ce_mode = 0;
    wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    ce_mode = 1;
    for (int n = 0; n < 4500 && starts < s0 + 2; n++) @(negedge clk_i);
    vec++;
    if (starts != s0 + 2 || tx_empty !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second_pop: starts=%0d empty=%b required 2 1", starts - s0, tx_empty);
    end
    vec++;
    if (last_gap != 1) begin
      errs++;
      $display("FAIL b2b_gap: got %0d idle ticks required 1", last_gap);
    end
    wait_frames(f0 + 2, 2200, "b2b");
  endtask

  task automatic test_clear();
    int s0;
    ce_mode = 0;
    wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    ce_mode = 1;
    for (int n = 0; n < 3000 && !(mon_on && mt >= 700); n++) @(negedge clk_i);
    vec++;
    if (!(mon_on && mt >= 700)) begin
      errs++;
      $display("FAIL clear_wait_timeout: mt=%0d required 700", mt);
    end
    clear = 1;
    @(negedge clk_i);
    clear = 0;
    exp_q.delete();
    s0 = starts;
    vec++;
    if ({txd, busy, tx_empty, overrun} !== 4'b1010) begin
      errs++;
      $display("FAIL clear: txd/busy/empty/ovr=%b required 1010", {txd, busy, tx_empty, overrun});
    end
    repeat (2500) @(negedge clk_i);
    vec++;
    if (starts != s0 || txd !== 1'b1) begin
      errs++;
      $display("FAIL clear_quiet: %0d new frames txd=%b required 0 frames txd=1", starts - s0, txd);
    end
  endtask

  task automatic test_async_reset();
    int f0;
    ce_mode = 1;
    wb_write('0, 1);
    for (int n = 0; n < 1000 && !(mon_on && mt >= 300); n++) @(negedge clk_i);
    vec++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset: txd=%b busy=%b required 0 1", txd, busy);
    end
    #2 rst_i = 0;
    #1;
    vec++;
    if ({txd, busy, tx_empty} !== 3'b101) begin
      errs++;
      $display("FAIL async_reset: txd/busy/empty=%b required 101", {txd, busy, tx_empty});
    end
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1;
    f0 = frames;
    wb_write({$urandom, $urandom, $urandom, $urandom}, 1);
    wait_frames(f0 + 1, 2200, "post_reset");
    vec++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL leftover: %0d words pending required 0", exp_q.size());
    end
  endtask

  initial begin
    cyc_i = 0; stb_i = 0; cs_i = 0; we_i = 0; dat_i = '0; clear = 0;
    baud16x_ce = 0; ce_mode = 0;
    fork
      drive_ce();
      monitor();
    join_none
    test_reset();
    test_single();
    test_ce_div();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
